// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} tx_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int frame_bits(input int data_w, input int stop_bits);
    return 1 + data_w + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Upper segment first (above the last winner), then wrap to the lower one.
    for (int i = 0; i < N; i++) begin
      if (!any && (i > int'(ptr)) && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && (i <= int'(ptr)) && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin shared UART transmitter: arbitrates byte requesters and frames 8N1-style
// output from an external 1x baud enable.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int ID_W      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      baud_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      txd,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  localparam int CNT_W = 4;

  tx_state_e           state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     idx;
  logic                any;
  logic [DATA_W-1:0]   sel_data;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
  end

  // Only IDLE may accept, and never while reset is being applied.
  assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
  assign txd       = txd_q;
  assign busy      = busy_q;
  assign grant_id  = gid_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: if (any) begin
        shift_d = sel_data;
        gid_d   = idx;
        ptr_d   = idx;
        busy_d  = 1'b1;
        state_d = SYNC;
      end
      SYNC: if (baud_en) begin
        txd_d   = 1'b0;
        state_d = START;
      end
      START: if (baud_en) begin
        txd_d   = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = CNT_W'(DATA_W - 1);
        state_d = DATA;
      end
      DATA: if (baud_en) begin
        if (cnt_q != '0) begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          txd_d   = 1'b1;
          cnt_d   = CNT_W'(STOP_BITS - 1);
          state_d = STOP;
        end
      end
      STOP: if (baud_en) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      gid_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

endmodule
